// File: rtl/rate_block_assembler.sv
// -----------------------------------------------------------------------------
// rate_block_assembler
//
// Purpose:
//   Packs CHUNK_WIDTH-wide chunks, MSB-first, into one RATE_WIDTH-bit Ascon-128
//   rate block and hands complete blocks downstream over a valid/ready
//   handshake. Optionally applies Ascon 10* padding.
//   chunk_ready feeds the shift_en input of the upstream chunk shift register.
//
// Configuration:
//   RATE_ASM_PAD_EN  defined   : 10* padding. The pad word is {1'b1, zeros}.
//                                It goes in the slot after the last chunk, or
//                                into a separate pad-only block when the last
//                                chunk fills the block.
//                    undefined : no padding. Unused slots stay zero. The block
//                                holding the last chunk carries block_last=1.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   chunk_valid  in   chunk_data valid this cycle
//   chunk_data   in   [CHUNK_WIDTH] data chunk
//   chunk_last   in   chunk is the final chunk of the message
//   flush        in   end of message without a chunk this cycle (pulse)
//   chunk_ready  out  assembler accepts a chunk/flush this cycle
//   block_valid  out  block_data holds a complete block
//   block_data   out  [RATE_WIDTH] assembled block, chunk k at
//                     [RATE_WIDTH-1-k*CHUNK_WIDTH -: CHUNK_WIDTH]
//   block_last   out  block is the final block of the message
//   block_cnt    out  [CW] number of message-data chunks in block_data
//   block_ready  in   consumer takes the block on block_valid && block_ready
// -----------------------------------------------------------------------------
module rate_block_assembler #(
    parameter int CHUNK_WIDTH = 8,
    parameter int RATE_WIDTH  = 64,
    localparam int NCHUNK     = RATE_WIDTH / CHUNK_WIDTH,
    localparam int CW         = $clog2(NCHUNK + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chunk_valid,
    input  logic [CHUNK_WIDTH-1:0] chunk_data,
    input  logic                   chunk_last,
    input  logic                   flush,
    output logic                   chunk_ready,
    output logic                   block_valid,
    output logic [RATE_WIDTH-1:0]  block_data,
    output logic                   block_last,
    output logic [CW-1:0]          block_cnt,
    input  logic                   block_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam logic [CHUNK_WIDTH-1:0] PAD_WORD  = {1'b1, {(CHUNK_WIDTH-1){1'b0}}};
    localparam logic [RATE_WIDTH-1:0]  PAD_BLOCK = {PAD_WORD, {(RATE_WIDTH-CHUNK_WIDTH){1'b0}}};
    localparam logic [CW-1:0]          LAST_SLOT = CW'(NCHUNK - 1);
    localparam logic [CW-1:0]          FULL_CNT  = CW'(NCHUNK);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0]   buf_q, buf_d;
    logic                    pad_pending_q, pad_pending_d;
    logic                    last_q, last_d;
    logic [CW-1:0]           bcnt_q, bcnt_d;
    logic                    is_last;

    // Write value v into slot k of block b. The loop over constant slot
    // positions keeps every part-select in range, whatever the value of k.
    function automatic logic [RATE_WIDTH-1:0] put_slot(
        input logic [RATE_WIDTH-1:0]  b,
        input logic [CW-1:0]          k,
        input logic [CHUNK_WIDTH-1:0] v
    );
        logic [RATE_WIDTH-1:0] r;
        r = b;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == CW'(i)) begin
                r[RATE_WIDTH-1-i*CHUNK_WIDTH -: CHUNK_WIDTH] = v;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            buf_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
            bcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
            bcnt_q        <= bcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        bcnt_d        = bcnt_q;
        // A flush that arrives together with a chunk marks that chunk as last.
        is_last       = chunk_last | flush;

        case (state_q)
            COLLECT: begin
                if (chunk_valid) begin
                    buf_d = put_slot(buf_q, cnt_q, chunk_data);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_SLOT) begin
                        state_d = EMIT;
                        bcnt_d  = FULL_CNT;
`ifdef RATE_ASM_PAD_EN
                        // There is no room for the pad word in a full block.
                        // It goes out as a separate pad-only block afterwards.
                        pad_pending_d = is_last;
                        last_d        = 1'b0;
`else
                        pad_pending_d = 1'b0;
                        last_d        = is_last;
`endif
                    end else if (is_last) begin
`ifdef RATE_ASM_PAD_EN
                        buf_d = put_slot(buf_d, cnt_q + CW'(1), PAD_WORD);
`endif
                        state_d = EMIT;
                        last_d  = 1'b1;
                        bcnt_d  = cnt_q + CW'(1);
                    end
                end else if (flush) begin
                    // When cnt_q == 0 this produces the pad-only block.
                    // Without padding it produces an all-zero block.
`ifdef RATE_ASM_PAD_EN
                    buf_d = put_slot(buf_q, cnt_q, PAD_WORD);
`endif
                    state_d = EMIT;
                    last_d  = 1'b1;
                    bcnt_d  = cnt_q;
                end
            end

            EMIT: begin
                if (block_ready) begin
                    if (pad_pending_q) begin
                        buf_d         = PAD_BLOCK;
                        bcnt_d        = '0;
                        last_d        = 1'b1;
                        pad_pending_d = 1'b0;
                    end else begin
                        state_d = COLLECT;
                        buf_d   = '0;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                        last_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // chunk_ready depends only on state, so there is no combinational path from block_ready.
    assign chunk_ready = (state_q == COLLECT);
    assign block_valid = (state_q == EMIT);
    assign block_data  = buf_q;
    assign block_last  = last_q;
    assign block_cnt   = bcnt_q;

endmodule

// File: tb/tb_rate_block_assembler.sv
module tb_rate_block_assembler;

`ifdef RATE_ASM_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        chunk_valid;
    logic [7:0]  chunk_data;
    logic        chunk_last;
    logic        flush;
    logic        chunk_ready;
    logic        block_valid;
    logic [63:0] block_data;
    logic        block_last;
    logic [3:0]  block_cnt;
    logic        block_ready;

    int tests = 0;
    int fails = 0;

    rate_block_assembler #(
        .CHUNK_WIDTH(8),
        .RATE_WIDTH (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chunk_valid(chunk_valid),
        .chunk_data (chunk_data),
        .chunk_last (chunk_last),
        .flush      (flush),
        .chunk_ready(chunk_ready),
        .block_valid(block_valid),
        .block_data (block_data),
        .block_last (block_last),
        .block_cnt  (block_cnt),
        .block_ready(block_ready)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        chunk_valid = 1'b1;
        chunk_data  = d;
        chunk_last  = l;
        cyc();
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
    endtask

    initial begin
        logic [63:0] b0, b1;
        logic        l1;
        int          cycles, blocks, sent;

        reset       = 1'b1;
        chunk_valid = 1'b0;
        chunk_data  = '0;
        chunk_last  = 1'b0;
        flush       = 1'b0;
        block_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", 64'(block_valid), 64'd0);
        chk("rst_data",  block_data,       64'd0);
        chk("rst_last",  64'(block_last),  64'd0);
        chk("rst_cnt",   64'(block_cnt),   64'd0);
        chk("rst_crdy",  64'(chunk_ready), 64'd1);
        reset = 1'b0;
        cyc();

        // Full block 01..08, last on 08, ready held high.
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        chk("A_valid", 64'(block_valid), 64'd1);
        chk("A_data",  block_data,       64'h0102030405060708);
        chk("A_cnt",   64'(block_cnt),   64'd8);
        chk("A_last",  64'(block_last),  PAD ? 64'd0 : 64'd1);
        chk("A_crdy",  64'(chunk_ready), 64'd0);
        cyc();
        chk("A2_valid", 64'(block_valid), PAD ? 64'd1 : 64'd0);
        chk("A2_data",  block_data,       PAD ? 64'h8000000000000000 : 64'd0);
        chk("A2_cnt",   64'(block_cnt),   64'd0);
        chk("A2_last",  64'(block_last),  PAD ? 64'd1 : 64'd0);
        cyc();
        chk("A3_valid", 64'(block_valid), 64'd0);
        chk("A3_crdy",  64'(chunk_ready), 64'd1);

        // Partial block AA,BB,CC with backpressure.
        block_ready = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        chk("B_valid", 64'(block_valid), 64'd1);
        chk("B_data",  block_data,       PAD ? 64'hAABBCC8000000000 : 64'hAABBCC0000000000);
        chk("B_cnt",   64'(block_cnt),   64'd3);
        chk("B_last",  64'(block_last),  64'd1);
        chunk_valid = 1'b1;
        chunk_data  = 8'h55;
        chunk_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("BP_valid", 64'(block_valid), 64'd1);
            chk("BP_data",  block_data,       PAD ? 64'hAABBCC8000000000 : 64'hAABBCC0000000000);
            chk("BP_crdy",  64'(chunk_ready), 64'd0);
            chk("BP_last",  64'(block_last),  64'd1);
        end
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
        block_ready = 1'b1;
        cyc();
        chk("B2_valid", 64'(block_valid), 64'd0);
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 1'b0);
        chk("B3_data", block_data,      64'h2122232425262728);
        chk("B3_cnt",  64'(block_cnt),  64'd8);
        chk("B3_last", 64'(block_last), 64'd0);
        cyc();
        chk("B4_valid", 64'(block_valid), 64'd0);

        // Reset after 4 accepted chunks.
        for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 1'b0);
        reset = 1'b1;
        cyc();
        chk("C_valid", 64'(block_valid), 64'd0);
        chk("C_data",  block_data,       64'd0);
        chk("C_cnt",   64'(block_cnt),   64'd0);
        chk("C_crdy",  64'(chunk_ready), 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i), 1'b0);
        chk("C2_valid", 64'(block_valid), 64'd1);
        chk("C2_data",  block_data,       64'h1112131415161718);
        chk("C2_cnt",   64'(block_cnt),   64'd8);
        cyc();

        // Flush with an empty buffer.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("D_valid", 64'(block_valid), 64'd1);
        chk("D_data",  block_data,       PAD ? 64'h8000000000000000 : 64'd0);
        chk("D_cnt",   64'(block_cnt),   64'd0);
        chk("D_last",  64'(block_last),  64'd1);
        cyc();
        chk("D2_valid", 64'(block_valid), 64'd0);

        // Flush after two chunks.
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("E_data", block_data,      PAD ? 64'h4142800000000000 : 64'h4142000000000000);
        chk("E_cnt",  64'(block_cnt),  64'd2);
        chk("E_last", 64'(block_last), 64'd1);
        cyc();

        // Chunk together with flush counts as the last chunk.
        flush = 1'b1;
        send(8'h51, 1'b0);
        flush = 1'b0;
        chk("F_data", block_data,      PAD ? 64'h5180000000000000 : 64'h5100000000000000);
        chk("F_cnt",  64'(block_cnt),  64'd1);
        chk("F_last", 64'(block_last), 64'd1);
        cyc();
        chk("F2_valid", 64'(block_valid), 64'd0);

        // Streaming 16 chunks with ready high: two blocks in 18 cycles.
        cycles = 0;
        blocks = 0;
        sent   = 0;
        b0     = '0;
        b1     = '0;
        l1     = 1'b0;
        while (blocks < 2 && cycles < 40) begin
            if (block_valid) begin
                if (blocks == 0) b0 = block_data;
                else begin
                    b1 = block_data;
                    l1 = block_last;
                end
                blocks++;
            end
            if (chunk_ready && sent < 16) begin
                chunk_valid = 1'b1;
                chunk_data  = 8'(8'h60 + sent);
                chunk_last  = (sent == 15) && !PAD;
                sent++;
            end else begin
                chunk_valid = 1'b0;
                chunk_last  = 1'b0;
            end
            cyc();
            cycles++;
        end
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
        chk("G_cycles", 64'(cycles), 64'd18);
        chk("G_blocks", 64'(blocks), 64'd2);
        chk("G_b0",     b0,          64'h6061626364656667);
        chk("G_b1",     b1,          64'h68696A6B6C6D6E6F);
        chk("G_last1",  64'(l1),     PAD ? 64'd0 : 64'd1);
        cyc();
        chk("G_idle",   64'(block_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
